// File: rtl/mul_float_arb_pkg.sv
// Shared types and constants for the mul_float_arb multiplier sequencer.
package mul_float_arb_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Bit positions inside rsp_flags ({nan, overflow, underflow, zero}).
  localparam int unsigned FLAG_NAN  = 3;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  localparam int unsigned DEFAULT_FLOAT_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past last_grant and wraps.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx[IDX_W-1:0]]) begin
        any   = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mul_float_arb.sv
// Shares one external float multiplier between NUM_REQ requesters (round-robin).
// Define MUL_FLOAT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_timeout.
module mul_float_arb
  import mul_float_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned FLOAT_WIDTH    = DEFAULT_FLOAT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [FLOAT_WIDTH-1:0]         rsp_data,
  output logic [3:0]                     rsp_flags,
  output logic                           rsp_timeout,
  output logic                           mul_start,
  output logic [FLOAT_WIDTH-1:0]         mul_op1,
  output logic [FLOAT_WIDTH-1:0]         mul_op2,
  input  logic [FLOAT_WIDTH-1:0]         mul_out,
  input  logic                           mul_nan,
  input  logic                           mul_overflow,
  input  logic                           mul_underflow,
  input  logic                           mul_zero,
  input  logic                           mul_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e               state_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic                 done_q;
  logic [IDX_W-1:0]     arb_grant;
  logic                 arb_any;
  logic [FLOAT_WIDTH-1:0] sel_op1;
  logic [FLOAT_WIDTH-1:0] sel_op2;
  logic [3:0]           flags_in;
  logic                 done_edge;
  logic                 timeout_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .grant     (arb_grant),
    .any       (arb_any)
  );

  assign sel_op1   = req_op1[FLOAT_WIDTH*32'(arb_grant) +: FLOAT_WIDTH];
  assign sel_op2   = req_op2[FLOAT_WIDTH*32'(arb_grant) +: FLOAT_WIDTH];
  assign done_edge = mul_done & ~done_q;

  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_NAN]  = mul_nan;
    flags_in[FLAG_OVF]  = mul_overflow;
    flags_in[FLAG_UNF]  = mul_underflow;
    flags_in[FLAG_ZERO] = mul_zero;
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && arb_any) req_ready = NUM_REQ'(1) << arb_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      done_q       <= 1'b0;
      mul_start    <= 1'b0;
      mul_op1      <= '0;
      mul_op2      <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
    end else begin
      // Tracking mul_done every cycle also covers loading it in ISSUE, so stale
      // edges from IDLE/ISSUE never complete a WAIT.
      done_q <= mul_done;
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            grant_q   <= arb_grant;
            mul_op1   <= sel_op1;
            mul_op2   <= sel_op2;
            mul_start <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          mul_start <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          if (done_edge) begin
            rsp_data  <= mul_out;
            rsp_flags <= flags_in;
            rsp_valid <= NUM_REQ'(1) << grant_q;
            state_q   <= StResp;
          end else if (timeout_hit) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_valid <= NUM_REQ'(1) << grant_q;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid    <= '0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MUL_FLOAT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign timeout_hit = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == StWait) && !done_edge && !timeout_hit) cnt_q <= cnt_q + 1'b1;
      else cnt_q <= '0;
      if ((state_q == StWait) && !done_edge && timeout_hit) timeout_q <= 1'b1;
      else if ((state_q == StResp) && rsp_ready[grant_q]) timeout_q <= 1'b0;
    end
  end
`else
  logic unused_timeout_cycles;

  assign timeout_hit           = 1'b0;
  assign rsp_timeout           = 1'b0;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mul_float_arb.sv
// Directed self-checking bench for mul_float_arb with a behavioural multiplier model.
module tb_mul_float_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_op1;
  logic [N*W-1:0]   req_op2;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [3:0]       rsp_flags;
  logic             rsp_timeout;
  logic             mul_start;
  logic [W-1:0]     mul_op1;
  logic [W-1:0]     mul_op2;
  logic [W-1:0]     mul_out = '0;
  logic             mul_nan = 1'b0;
  logic             mul_overflow = 1'b0;
  logic             mul_underflow = 1'b0;
  logic             mul_zero = 1'b0;
  logic             mul_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_float_arb #(
    .NUM_REQ       (N),
    .FLOAT_WIDTH   (W),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_timeout  (rsp_timeout),
    .mul_start    (mul_start),
    .mul_op1      (mul_op1),
    .mul_op2      (mul_op2),
    .mul_out      (mul_out),
    .mul_nan      (mul_nan),
    .mul_overflow (mul_overflow),
    .mul_underflow(mul_underflow),
    .mul_zero     (mul_zero),
    .mul_done     (mul_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed IEEE-754 products, returned as {flags, result}.
  function automatic logic [35:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40A00000, 32'h40A00000}: return {4'b0000, 32'h41C80000};
      {32'h00000000, 32'h40A00000}: return {4'b0001, 32'h00000000};
      {32'h3F800000, 32'h40000000}: return {4'b0000, 32'h40000000};
      {32'h40000000, 32'h40000000}: return {4'b0000, 32'h40800000};
      {32'h40400000, 32'h40000000}: return {4'b0000, 32'h40C00000};
      {32'h40800000, 32'h40000000}: return {4'b0000, 32'h41000000};
      default:                      return {4'b1000, 32'h7FC00000};
    endcase
  endfunction

  // Multiplier model: one-cycle mul_done pulse 5 cycles after mul_start.
  int unsigned m_cnt = 0;
  int unsigned m_delay = 5;
  logic        m_en = 1'b1;
  int unsigned starts = 0;

  always @(posedge clk) begin
    if (mul_start) begin
      starts <= starts + 1;
      m_cnt  <= m_delay;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
    if (m_en && (m_cnt == 1) && !mul_start) begin
      mul_done <= 1'b1;
      {mul_nan, mul_overflow, mul_underflow, mul_zero, mul_out} <= fmul_lut(mul_op1, mul_op2);
    end else begin
      mul_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot_req_ready", 32'($countones(req_ready) <= 1), 32'd1);
      check("onehot_rsp_valid", 32'($countones(rsp_valid) <= 1), 32'd1);
    end
  end

  task automatic wait_for_done(input string tag);
    int n = 0;
    while (mul_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(mul_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] rr_op1 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] rr_res [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  initial begin
    logic seen_rsp;
    logic seen_done;
    int   s0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_op1", mul_op1, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5.0 * 5.0 from requester 0
    req_op1[31:0] = 32'h40A00000;
    req_op2[31:0] = 32'h40A00000;
    req_valid     = 4'b0001;
    #1 check("t1_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("t1_req_ready_issue", 32'(req_ready), 32'd0);
    req_valid = '0;
    check("t1_mul_start", 32'(mul_start), 32'd1);
    check("t1_mul_op1", mul_op1, 32'h40A00000);
    check("t1_mul_op2", mul_op2, 32'h40A00000);
    @(negedge clk);
    check("t1_start_one_cycle", 32'(mul_start), 32'd0);
    wait_for_done("t1");
    check("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", rsp_data, 32'h41C80000);
    check("t1_rsp_flags", 32'(rsp_flags), 32'd0);
    check("t1_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    check("t1_rsp_released", 32'(rsp_valid), 32'd0);

    // 0.0 * 5.0: zero flag, response held, foreign rsp_ready ignored, back-to-back accept
    req_op1[31:0] = 32'h00000000;
    req_op2[31:0] = 32'h40A00000;
    req_valid     = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    wait_for_done("t2");
    @(negedge clk);
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_data", rsp_data, 32'd0);
    check("t2_rsp_flags", 32'(rsp_flags), 32'b0001);
    rsp_ready = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(rsp_valid), 32'd1);
      check("t2_hold_flags", 32'(rsp_flags), 32'b0001);
    end
    req_op1[31:0] = 32'h40A00000;
    req_op2[31:0] = 32'h40A00000;
    req_valid     = 4'b0001;
    rsp_ready     = 4'b0001;
    #1 check("t2_no_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = '0;
    check("t2_rsp_released", 32'(rsp_valid), 32'd0);
    check("t2_b2b_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    check("t2_b2b_start", 32'(mul_start), 32'd1);
    wait_for_done("t2b");
    @(negedge clk);
    check("t2_b2b_data", rsp_data, 32'h41C80000);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;

    // reset asserted while waiting on the multiplier
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t3_rst_mul_start", 32'(mul_start), 32'd0);
    check("t3_rst_mul_op1", mul_op1, 32'd0);
    check("t3_rst_rsp_data", rsp_data, 32'd0);
    check("t3_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t3_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_rsp  = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_rsp  = seen_rsp | (|rsp_valid);
      seen_done = seen_done | mul_done;
    end
    check("t3_late_done_seen", 32'(seen_done), 32'd1);
    check("t3_no_rsp_after_rst", 32'(seen_rsp), 32'd0);

    // all four requesters held valid: grants 0,1,2,3,0
    for (int r = 0; r < 4; r++) begin
      req_op1[r*W +: W] = rr_op1[r];
      req_op2[r*W +: W] = 32'h40000000;
    end
    req_valid = 4'hF;
    s0        = int'(starts);
    for (int k = 0; k < 5; k++) begin
      int g;
      int n;
      g = k % 4;
      n = 0;
      #1;
      while (req_ready === '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t4_grant", 32'(req_ready), 32'(1) << g);
      @(negedge clk);
      check("t4_mul_start", 32'(mul_start), 32'd1);
      check("t4_mul_op1", mul_op1, rr_op1[g]);
      wait_for_done("t4");
      @(negedge clk);
      check("t4_rsp_valid", 32'(rsp_valid), 32'(1) << g);
      check("t4_rsp_data", rsp_data, rr_res[g]);
      rsp_ready = 4'(1 << g);
      @(negedge clk);
      rsp_ready = '0;
      if (k == 4) req_valid = '0;
    end
    check("t4_start_count", 32'(int'(starts) - s0), 32'd5);

`ifdef MUL_FLOAT_ARB_TIMEOUT_EN
    begin
      int n;
      m_en          = 1'b0;
      req_op1[31:0] = 32'h40A00000;
      req_op2[31:0] = 32'h40A00000;
      req_valid     = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      check("t5_mul_start", 32'(mul_start), 32'd1);
      n = 0;
      while (rsp_valid === '0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("t5_latency", 32'(n), 32'd65);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_rsp_timeout", 32'(rsp_timeout), 32'd1);
      check("t5_rsp_data", rsp_data, 32'd0);
      check("t5_rsp_flags", 32'(rsp_flags), 32'd0);
      rsp_ready = 4'b0001;
      @(negedge clk);
      rsp_ready = '0;
      check("t5_timeout_cleared", 32'(rsp_timeout), 32'd0);
      m_en = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
